seq_mult_nbit: RTL and testbench
================================

Name: seq_mult_nbit

Overview:
- Unsigned n×n → 2n-bit sequential shift-and-add multiplier.
- Each iteration's partial-product addition runs through one instance of the existing rca_nbit adder, so the block consumes what that adder produces, one add per cycle.
- Operands enter and the product leaves over valid/ready handshakes.
- Throughput is one product per n+2 cycles. The block is the small-area alternative to an array multiplier.

Parameters:
- n, 4, operand width in bits (n ≥ 1). Product width is 2n. The iteration counter is $clog2(n+1) bits wide.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  n  multiplicand, unsigned.
- b  input  n  multiplier, unsigned.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2n  a*b, unsigned.

Behaviour:
- Registers:
  - M (n bits): latched multiplicand.
  - A (n bits): upper accumulator.
  - Q (n bits): multiplier, which shifts into the product's low half.
  - C (1 bit): carry.
  - cnt: iterations remaining.
  - state: one of IDLE, RUN, DONE.
- Reset (rst=1 at an edge), overriding everything:
  - state=IDLE; A, Q, M, C, cnt = 0.
  - Outputs after reset: in_ready=1, out_valid=0, product=0.
  - Reset during RUN or DONE aborts the operation. No out_valid is produced and the result is discarded.
- Combinational outputs: in_ready = (state==IDLE); out_valid = (state==DONE); product = {A,Q}.
- IDLE:
  - If in_valid, then M←a, Q←b, A←0, C←0, cnt←n, and state→RUN.
  - Otherwise all registers hold.
- RUN, one iteration per cycle:
  - The adder computes {cout,sum} = A + M with c_in=0.
  - If Q[0]=1: {C,A,Q} ← {cout, sum, Q} >> 1.
  - If Q[0]=0: {C,A,Q} ← {1'b0, A, Q} >> 1.
  - cnt ← cnt−1. When cnt==1 at the edge, state→DONE.
- DONE:
  - product is held stable while out_valid && !out_ready.
  - If out_ready, state→IDLE; A and Q keep their values until the next acceptance.
- Latency:
  - If operands are accepted at edge t, RUN occupies edges t+1 … t+n.
  - out_valid is high from the cycle after edge t+n.
  - If out_ready is high, out_valid lasts exactly 1 cycle. The next operands can be accepted 1 cycle after the handshake; there is no overlap.
- Boundaries:
  - in_valid during RUN or DONE is ignored (in_ready=0). Operands must be held by the producer until accepted.
  - n=1 requires exactly one RUN cycle.
  - The maximum result (2^n−1)^2 must fit 2n bits with no overflow, and C never propagates out of the product.
  - a=0 or b=0 still takes the full n cycles; there is no early termination.
  - a and b are sampled only at the acceptance edge. Later changes have no effect.

Decomposition:
- No shared package. The state encoding (IDLE=0, RUN=1, DONE=2) is a set of local constants private to this block.
- Sub-module: one rca_nbit #(.n(n)) instance for the A+M add, with c_in tied to 0 and c_out feeding C.
- The datapath registers and the FSM stay in seq_mult_nbit.

Test Plan:
- n=4, a=13, b=11, out_ready=1 → out_valid 5 cycles after acceptance (n+1), product=143 (0x8F), out_valid high for exactly 1 cycle.
- n=4, a=15, b=15 → product=225 (0xE1); also a=0, b=9 → product=0 after the full 4 RUN cycles.
- Backpressure: out_ready=0 for 6 cycles after out_valid → product and out_valid held stable with in_ready=0; out_ready=1 → IDLE next cycle, in_ready=1.
- In RUN, apply in_valid=1 with a=3, b=3 → ignored; the first result is unaffected (e.g. 7*6=42).
- Assert rst=1 for 1 cycle during the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, product=0; the following op 5*5 → 25.
- n=8, a=255, b=255 → product=65025 (0xFE01), out_valid 9 cycles after acceptance; n=1, a=1, b=1 → product=1 after 2 cycles.

Source files
------------

// File: rtl/rca_nbit.sv
// Ripple-carry adder: n full-adder cells chained through a carry vector.
// The sequential multiplier uses it for one partial-product add per cycle.
module rca_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] sum,
  output logic         c_out
);

  logic [n:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_fa
      assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[n];

endmodule

// File: rtl/seq_mult_nbit.sv
// Unsigned n x n -> 2n shift-and-add multiplier; one add per cycle through rca_nbit,
// operands in and product out over valid/ready handshakes.
module seq_mult_nbit #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] product
);

  localparam int CW = $clog2(n + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [n-1:0]  m_reg, m_next;
  logic [n-1:0]  a_reg, a_next;
  logic [n-1:0]  q_reg, q_next;
  logic          c_reg, c_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [n-1:0]  add_sum;
  logic          add_cout;

  rca_nbit #(.n(n)) u_add (
    .a     (a_reg),
    .b     (m_reg),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    a_next     = a_reg;
    q_next     = q_reg;
    c_next     = c_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          m_next     = a;
          q_next     = b;
          a_next     = '0;
          c_next     = 1'b0;
          cnt_next   = CW'(n);
          state_next = RUN;
        end
      end
      RUN: begin
        // The carry re-enters as the accumulator MSB, so nothing escapes the 2n-bit product.
        if (q_reg[0])
          {c_next, a_next, q_next} = {add_cout, add_sum, q_reg} >> 1;
        else
          {c_next, a_next, q_next} = {1'b0, a_reg, q_reg} >> 1;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1))
          state_next = DONE;
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      a_reg     <= a_next;
      q_reg     <= q_next;
      c_reg     <= c_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign product   = {a_reg, q_reg};

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Self-checking bench for seq_mult_nbit at n=4, n=8 and n=1 against a*b computed arithmetically.
module tb_seq_mult_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] product4;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic [1:0] product1;

  seq_mult_nbit #(.n(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .product(product4)
  );
  seq_mult_nbit #(.n(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );
  seq_mult_nbit #(.n(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .product(product1)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One n=4 transaction: optional poke of new operands during RUN, optional DONE stall.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input int stall, input bit poke);
    int exp_p;
    int k;
    exp_p = int'(av) * int'(bv);
    in_valid4  = 1'b1;
    a4         = av;
    b4         = bv;
    out_ready4 = (stall == 0);
    step();
    check("n4_accept_in_ready_low", 64'(in_ready4), 64'd0);
    in_valid4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    k = 0;
    while (!out_valid4 && k < 40) begin
      if (poke && k < 2) begin
        in_valid4 = 1'b1;
        a4 = 4'd3;
        b4 = 4'd3;
      end else begin
        in_valid4 = 1'b0;
      end
      step();
      k++;
    end
    in_valid4 = 1'b0;
    $display("n4 op %0d*%0d -> product=%0d after %0d edges", av, bv, product4, k);
    check("n4_latency_edges", 64'(k), 64'd4);
    check("n4_product", 64'(product4), 64'(exp_p));
    for (int s = 0; s < stall; s++) begin
      step();
      check("n4_stall_out_valid", 64'(out_valid4), 64'd1);
      check("n4_stall_product", 64'(product4), 64'(exp_p));
      check("n4_stall_in_ready", 64'(in_ready4), 64'd0);
    end
    out_ready4 = 1'b1;
    step();
    check("n4_post_out_valid", 64'(out_valid4), 64'd0);
    check("n4_post_in_ready", 64'(in_ready4), 64'd1);
    check("n4_post_product_hold", 64'(product4), 64'(exp_p));
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv);
    int exp_p;
    int k;
    exp_p = int'(av) * int'(bv);
    in_valid8 = 1'b1;
    a8 = av;
    b8 = bv;
    step();
    in_valid8 = 1'b0;
    a8 = 8'($urandom);
    k = 0;
    while (!out_valid8 && k < 40) begin
      step();
      k++;
    end
    $display("n8 op %0d*%0d -> product=%0d after %0d edges", av, bv, product8, k);
    check("n8_latency_edges", 64'(k), 64'd8);
    check("n8_product", 64'(product8), 64'(exp_p));
    step();
    check("n8_post_out_valid", 64'(out_valid8), 64'd0);
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv);
    int exp_p;
    int k;
    exp_p = int'(av) * int'(bv);
    in_valid1 = 1'b1;
    a1 = av;
    b1 = bv;
    step();
    in_valid1 = 1'b0;
    k = 0;
    while (!out_valid1 && k < 40) begin
      step();
      k++;
    end
    $display("n1 op %0d*%0d -> product=%0d after %0d edges", av, bv, product1, k);
    check("n1_latency_edges", 64'(k), 64'd1);
    check("n1_product", 64'(product1), 64'(exp_p));
    step();
    check("n1_post_out_valid", 64'(out_valid1), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready4), 64'd1);
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_product", 64'(product4), 64'd0);
    check("rst_n8_product", 64'(product8), 64'd0);

    op4(4'd13, 4'd11, 0, 1'b0);
    op4(4'd15, 4'd15, 0, 1'b0);
    op4(4'd0,  4'd9,  0, 1'b0);
    op4(4'd9,  4'd0,  0, 1'b0);
    op4(4'd7,  4'd6,  6, 1'b0);
    op4(4'd7,  4'd6,  0, 1'b1);

    // Abort during the second RUN cycle.
    in_valid4 = 1'b1;
    a4 = 4'd14;
    b4 = 4'd13;
    step();
    in_valid4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("n4 reset mid-run -> in_ready=%0d out_valid=%0d product=%0d", in_ready4, out_valid4, product4);
    check("abort_in_ready", 64'(in_ready4), 64'd1);
    check("abort_out_valid", 64'(out_valid4), 64'd0);
    check("abort_product", 64'(product4), 64'd0);
    op4(4'd5, 4'd5, 0, 1'b0);

    for (int i = 0; i < 8; i++)
      op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    op8(8'd255, 8'd255);
    for (int i = 0; i < 4; i++)
      op8(8'($urandom), 8'($urandom));

    op1(1'b1, 1'b1);
    op1(1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
